// File: rtl/exp_pkg.sv
// Shared constants and helpers for the fixed-point exponential unit.
// Reciprocal factorials feed the Horner coefficients; saturate clips to a signed width.
package exp_pkg;

    localparam int unsigned MaxTerms = 6;

    // Rounded 2^frac_bits / k!
    function automatic longint recip_fact(input int unsigned k, input int unsigned frac_bits);
        longint fact;
        longint one;
        fact = 1;
        for (int unsigned i = 2; i <= k; i++) begin
            fact = fact * longint'(i);
        end
        one = longint'(1) << frac_bits;
        return (one + fact / 2) / fact;
    endfunction

    function automatic longint saturate(input longint v, input int unsigned width);
        longint hi;
        longint lo;
        hi = (longint'(1) << (width - 1)) - 1;
        lo = -(longint'(1) << (width - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/exp_horner_stage.sv
// One registered Horner step: acc_o = ((acc_i * x_i) >>> F) + Coef, with a valid bit.
module exp_horner_stage #(
    parameter int unsigned W    = 32,
    parameter int unsigned F    = 20,
    parameter longint      Coef = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic signed [W-1:0] acc_i,
    input  logic signed [W-1:0] x_i,
    output logic                valid_o,
    output logic signed [W-1:0] acc_o
);

    logic signed [2*W-1:0] prod;
    logic signed [W-1:0]   acc_d;
    logic signed [W-1:0]   acc_q;
    logic                  valid_q;

    always_comb begin
        prod  = (2*W)'(acc_i) * (2*W)'(x_i);
        acc_d = W'(prod >>> F) + W'(Coef);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/exp_taylor.sv
// Pipelined truncated-Taylor e^x in fixed point: clamp/capture, Horner chain,
// saturation to the output format, then delay padding to a fixed latency.
module exp_taylor
    import exp_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH        = 33,
    parameter int unsigned INPUT_FRAC_BITS    = 16,
    parameter int unsigned OUTPUT_WIDTH       = 16,
    parameter int unsigned OUTPUT_FRAC_BITS   = 15,
    parameter int unsigned NUM_TERMS          = 4,
    parameter int unsigned INTERNAL_FRAC_BITS = 20,
    parameter int unsigned LATENCY            = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_exp,
    input  logic [INPUT_WIDTH-1:0]  x_in,
    output logic [OUTPUT_WIDTH-1:0] y_out,
    output logic                    exp_done
);

    localparam int unsigned F         = INTERNAL_FRAC_BITS;
    localparam int unsigned W         = INTERNAL_FRAC_BITS + 12;
    localparam int unsigned Stages    = NUM_TERMS - 1;
    localparam int unsigned XDepth    = (Stages > 0) ? Stages : 1;
    localparam int          PadStages = int'(LATENCY) - int'(NUM_TERMS);
    localparam int          ShiftIn   = int'(F) - int'(INPUT_FRAC_BITS);
    localparam int          ShiftOut  = int'(F) - int'(OUTPUT_FRAC_BITS);
    localparam longint      XMax      = (longint'(8) << INPUT_FRAC_BITS) - 1;
    localparam longint      XMin      = -(longint'(8) << INPUT_FRAC_BITS);

    logic signed [INPUT_WIDTH-1:0] x_s;
    longint                        x_ext;
    longint                        x_clamp;
    longint                        x_conv;
    logic                          vld_q;
    // x_pipe_q[i] is the operand for Horner stage i, aligned with its accumulator.
    logic signed [W-1:0]           x_pipe_q [XDepth];

    assign x_s = x_in;

    always_comb begin
        x_ext   = longint'(x_s);
        x_clamp = x_ext;
        if (x_ext > XMax) begin
            x_clamp = XMax;
        end else if (x_ext < XMin) begin
            x_clamp = XMin;
        end
        if (ShiftIn >= 0) begin
            x_conv = x_clamp <<< ShiftIn;
        end else begin
            x_conv = x_clamp >>> (-ShiftIn);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            for (int i = 0; i < int'(XDepth); i++) begin
                x_pipe_q[i] <= '0;
            end
        end else begin
            vld_q <= start_exp;
            if (start_exp) begin
                x_pipe_q[0] <= W'(x_conv);
            end
            for (int i = 1; i < int'(XDepth); i++) begin
                x_pipe_q[i] <= x_pipe_q[i-1];
            end
        end
    end

    logic signed [W-1:0] acc_pipe [NUM_TERMS];
    logic                vld_pipe [NUM_TERMS];

    assign acc_pipe[0] = W'(recip_fact(NUM_TERMS - 1, F));
    assign vld_pipe[0] = vld_q;

    for (genvar i = 0; i < int'(Stages); i++) begin : g_stage
        exp_horner_stage #(
            .W    (W),
            .F    (F),
            .Coef (recip_fact(NUM_TERMS - 2 - i, F))
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (vld_pipe[i]),
            .acc_i   (acc_pipe[i]),
            .x_i     (x_pipe_q[i]),
            .valid_o (vld_pipe[i+1]),
            .acc_o   (acc_pipe[i+1])
        );
    end

    longint                  sum_ext;
    logic                    sat_vld;
    logic [OUTPUT_WIDTH-1:0] sat_y;

    always_comb begin
        sum_ext = longint'(acc_pipe[Stages]);
        if (ShiftOut >= 0) begin
            sum_ext = sum_ext >>> ShiftOut;
        end else begin
            sum_ext = sum_ext <<< (-ShiftOut);
        end
        sat_y   = OUTPUT_WIDTH'(saturate(sum_ext, OUTPUT_WIDTH));
        sat_vld = vld_pipe[Stages];
    end

    logic                    tail_vld;
    logic [OUTPUT_WIDTH-1:0] tail_y;

    if (PadStages > 0) begin : g_pad
        logic                    pad_vld_q [PadStages];
        logic [OUTPUT_WIDTH-1:0] pad_y_q   [PadStages];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PadStages; i++) begin
                    pad_vld_q[i] <= 1'b0;
                    pad_y_q[i]   <= '0;
                end
            end else begin
                pad_vld_q[0] <= sat_vld;
                pad_y_q[0]   <= sat_y;
                for (int i = 1; i < PadStages; i++) begin
                    pad_vld_q[i] <= pad_vld_q[i-1];
                    pad_y_q[i]   <= pad_y_q[i-1];
                end
            end
        end

        assign tail_vld = pad_vld_q[PadStages-1];
        assign tail_y   = pad_y_q[PadStages-1];
    end else begin : g_no_pad
        assign tail_vld = sat_vld;
        assign tail_y   = sat_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_done <= 1'b0;
            y_out    <= '0;
        end else begin
            exp_done <= tail_vld;
            if (tail_vld) begin
                y_out <= tail_y;
            end
        end
    end

endmodule

// File: tb/tb_exp_taylor.sv
// Directed-vector bench for exp_taylor: latency, values, saturation, ordering and reset abort.
module tb_exp_taylor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_exp;
    logic [32:0] x_in;
    logic [15:0] y_out;
    logic        exp_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exp_taylor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_exp (start_exp),
        .x_in      (x_in),
        .y_out     (y_out),
        .exp_done  (exp_done)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Single start; expects exactly one exp_done 5 cycles later carrying y_exp.
    task automatic run_one(input string tag, input longint x, input longint y_exp);
        int                 done_at;
        int                 pulses;
        logic signed [63:0] y_got;
        done_at = -1;
        pulses  = 0;
        y_got   = 'x;
        @(negedge clk);
        start_exp = 1'b1;
        x_in      = 33'(x);
        @(posedge clk);
        #1;
        start_exp = 1'b0;
        x_in      = 33'(131072);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (exp_done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = c;
                    y_got   = $signed(y_out);
                end
            end
        end
        check({tag, " latency"}, done_at, 5);
        check({tag, " pulses"}, pulses, 1);
        check({tag, " value"}, y_got, y_exp);
        check({tag, " hold"}, $signed(y_out), y_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint xs [4];
        longint ys [4];
        int     k;
        int     pulses;

        xs = '{0, -32768, -65536, -131072};
        ys = '{32767, 19797, 10922, -10923};

        rst_n     = 1'b0;
        start_exp = 1'b0;
        x_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset y_out", $signed(y_out), 0);
        check("reset exp_done", exp_done, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (exp_done === 1'b1) pulses++;
        end
        check("idle after reset", pulses, 0);

        run_one("x=0.0", 0, 32767);
        run_one("x=-0.5", -32768, 19797);
        run_one("x=-1.0", -65536, 10922);
        run_one("x=-2.0", -131072, -10923);
        run_one("x=-4.0", -262144, -32768);
        run_one("x=-100 clamp", -6553600, -32768);

        // Four starts on consecutive edges.
        @(negedge clk);
        start_exp = 1'b1;
        x_in      = 33'(xs[0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            x_in = 33'(xs[i]);
        end
        @(negedge clk);
        start_exp = 1'b0;
        k = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b done c%0d", c), exp_done, (c >= 2 && c <= 5) ? 1 : 0);
            if (exp_done === 1'b1 && k < 4) begin
                check($sformatf("b2b y%0d", k), $signed(y_out), ys[k]);
                k++;
            end
        end
        check("b2b count", k, 4);

        // Reset two cycles into a computation must discard it.
        @(negedge clk);
        start_exp = 1'b1;
        x_in      = 33'(-65536);
        @(posedge clk);
        #1;
        start_exp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort y_out", $signed(y_out), 0);
        check("abort exp_done", exp_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (exp_done === 1'b1) pulses++;
        end
        check("abort no done", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_taylor.md
# exp_taylor

Fixed-point exponential approximation unit for the transformer softmax path. Evaluates the truncated Taylor series e^x ≈ Σ_{k=0}^{NUM_TERMS-1} x^k/k! on a signed fixed-point input. Returns a saturated signed Q1.15 result after a fixed pipeline latency. Intended for x ≤ 0 (max-subtracted softmax logits).

## Interface
- INPUT_WIDTH, 33, width of signed input x_in
- INPUT_FRAC_BITS, 16, fractional bits of x_in
- OUTPUT_WIDTH, 16, width of signed output y_out
- OUTPUT_FRAC_BITS, 15, fractional bits of y_out
- NUM_TERMS, 4, number of series terms (k = 0..NUM_TERMS-1); supported range 1..6
- INTERNAL_FRAC_BITS, 20, fractional bits of internal arithmetic
- LATENCY, 5, cycles from start_exp sample to exp_done; must be ≥ 4

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_exp  in  1  x_in valid, sampled on rising edge
- x_in  in  INPUT_WIDTH  signed input, Q(INPUT_WIDTH-INPUT_FRAC_BITS).INPUT_FRAC_BITS
- y_out  out  OUTPUT_WIDTH  signed result, Q(OUTPUT_WIDTH-OUTPUT_FRAC_BITS).OUTPUT_FRAC_BITS
- exp_done  out  1  one-cycle pulse, y_out valid

## Operation
- On start_exp=1 at a rising edge, capture x_in.
- Clamp the captured value to [-8.0, +8.0 - 1 LSB].
- Convert to signed Q.INTERNAL_FRAC_BITS by shift, truncating when narrowing.
- Internal datapath width: INTERNAL_FRAC_BITS + 12 bits, signed.
- Evaluate the series in Horner form: acc = 1/(N-1)!; acc = acc·x + 1/(k)! for k = N-2 down to 0.
- Reciprocal-factorial constants are rounded to Q.INTERNAL_FRAC_BITS.
- After each multiply, arithmetic-shift right by INTERNAL_FRAC_BITS (truncate).
- Convert the sum to Q.OUTPUT_FRAC_BITS by arithmetic shift, truncating.
- Saturate the result to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - e^0 = 1.0 therefore yields 32767.
- Accuracy requirement: within ±2 output LSB of the ideal truncated series, for any in-range result with x in [-2, 0].
- NUM_TERMS=1 gives constant 1.0, saturated to 32767.

## Timing
- Fully pipelined: accepts start_exp every cycle; one result per cycle.
- exp_done is asserted exactly LATENCY cycles after the edge that sampled start_exp, for one cycle.
- y_out updates in the same cycle as exp_done.
- y_out holds its last value until the next exp_done.
- Back-to-back starts yield back-to-back exp_done pulses, in order.
- Arithmetic may be distributed over stages freely. Stages beyond what the arithmetic needs are plain delay registers, so total latency equals LATENCY exactly.
- x_in is only sampled when start_exp=1; its value in other cycles is ignored.
- Reset (rst_n low, any time):
  - y_out = 0 and exp_done = 0 immediately.
  - All in-flight valid bits are cleared.
  - Pending results are discarded and produce no exp_done after reset release.
- First start_exp accepted: the first rising edge with rst_n high.

## Structure
- Shared package, exp_pkg:
  - Reciprocal-factorial constant function/table (1/k!, k = 0..5) in Q.INTERNAL_FRAC_BITS.
  - Saturation helper function.
- One sub-module is natural: exp_horner_stage. It is one registered multiply-add step (acc·x >> F + c) with a valid bit, and is instantiated NUM_TERMS-1 times.
- The top level holds:
  - Input capture and clamp stage.
  - Output saturation stage.
  - Padding delay registers.

## Test plan
- Reset: hold rst_n low 3 cycles → y_out = 0, exp_done = 0; no exp_done after release without start_exp.
- x = 0.0 (x_in = 0) → exp_done 5 cycles after start; y_out = 32767 (saturated 1.0).
- x = -0.5 (x_in = -32768) → y_out = 19797 ±2 (0.604167).
- x = -1.0 (-65536) → y_out = 10922 ±2 (0.33333).
- x = -2.0 (-131072) → y_out = -10922 ±2 (-0.33333).
- Saturation and ordering:
  - Single start at x = -4.0 (-262144) → y_out = -32768 (series value -5.667 saturated).
  - Then starts on 4 consecutive cycles with x = 0, -0.5, -1, -2 → 4 consecutive exp_done pulses with the values above, in order.
  - Then assert rst_n low 2 cycles after a start → that result never signals exp_done.
